puf_response_collector: RTL and testbench



---
 rtl/puf_response_collector.sv | 145 ++++++++++++++
 tb/tb_puf_response_collector.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_response_collector.sv
// Arbiter-PUF response collector: sequences challenge/settle/race/sample per bit and returns an N-bit word.
// Optional build macro PUF_MAJORITY_VOTE_EN races each challenge three times and stores the majority bit.
module puf_response_collector #(
  parameter int RESP_BITS      = 8,
  parameter int CHAL_WIDTH     = 8,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CHAL_WIDTH-1:0] challenge_seed,
  output logic                  busy,
  output logic [CHAL_WIDTH-1:0] chal_out,
  output logic                  arb_reset,
  output logic                  launch,
  input  logic                  arb_done,
  input  logic                  arb_out,
  output logic [RESP_BITS-1:0]  response,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  timeout_err
);
  localparam int IDX_W = $clog2(RESP_BITS + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ARM, RACE, SAMPLE, SHIFT, DONE} state_t;

  state_t                state, state_nxt;
  logic [CHAL_WIDTH-1:0] seed_r;
  logic [IDX_W-1:0]      index;
  logic [SET_W-1:0]      settle_cnt;
  logic [TO_W-1:0]       wait_cnt;
  logic                  done_meta_p0, done_s;
  logic                  new_bit, commit, last_bit, settle_last, race_expired;
  logic [RESP_BITS:0]    shifted;
`ifdef PUF_MAJORITY_VOTE_EN
  logic [1:0]            race_cnt, ones_cnt;
`else
  logic                  bit_r;
`endif

  // Race controls decode straight from state so an async reset forces arb_reset at once.
  assign arb_reset  = (state != RACE);
  assign launch     = (state == RACE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == DONE);
  assign chal_out   = seed_r + CHAL_WIDTH'(index);

  assign last_bit     = (index == IDX_W'(RESP_BITS - 1));
  assign settle_last  = (settle_cnt == SET_W'(SETTLE_CYCLES - 1));
  assign race_expired = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`ifdef PUF_MAJORITY_VOTE_EN
  assign new_bit = (ones_cnt >= 2'd2);
  assign commit  = (state == SHIFT) && (race_cnt == 2'd2);
`else
  assign new_bit = bit_r;
  assign commit  = (state == SHIFT);
`endif
  assign shifted = {response, new_bit};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ARM;
      ARM:     if (settle_last) state_nxt = RACE;
      RACE:    if (done_s) state_nxt = SAMPLE;
               else if (race_expired) state_nxt = SHIFT;
      SAMPLE:  state_nxt = SHIFT;
      SHIFT:   state_nxt = (commit && last_bit) ? DONE : ARM;
      DONE:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      seed_r       <= '0;
      index        <= '0;
      settle_cnt   <= '0;
      wait_cnt     <= '0;
      done_meta_p0 <= 1'b0;
      done_s       <= 1'b0;
      response     <= '0;
      timeout_err  <= 1'b0;
`ifdef PUF_MAJORITY_VOTE_EN
      race_cnt     <= '0;
      ones_cnt     <= '0;
`else
      bit_r        <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      // Synchronizer is flushed while the arbiter is held in reset, so RACE never sees a stale done.
      done_meta_p0 <= (state == ARM) ? 1'b0 : arb_done;
      done_s       <= (state == ARM) ? 1'b0 : done_meta_p0;
      case (state)
        IDLE: if (start) begin
          seed_r      <= challenge_seed;
          response    <= '0;
          timeout_err <= 1'b0;
          index       <= '0;
          settle_cnt  <= '0;
`ifdef PUF_MAJORITY_VOTE_EN
          race_cnt    <= '0;
          ones_cnt    <= '0;
`endif
        end
        ARM: begin
          settle_cnt <= settle_last ? '0 : settle_cnt + 1'b1;
          wait_cnt   <= '0;
        end
        RACE: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (!done_s && race_expired) begin
            timeout_err <= 1'b1;
`ifndef PUF_MAJORITY_VOTE_EN
            bit_r       <= 1'b0;
`endif
          end
        end
        SAMPLE: begin
`ifdef PUF_MAJORITY_VOTE_EN
          ones_cnt <= ones_cnt + {1'b0, arb_out};
`else
          bit_r    <= arb_out;
`endif
        end
        SHIFT: begin
          if (commit) begin
            response <= shifted[RESP_BITS-1:0];
            index    <= index + 1'b1;
          end
`ifdef PUF_MAJORITY_VOTE_EN
          race_cnt <= commit ? 2'd0 : race_cnt + 2'd1;
          if (commit) ones_cnt <= '0;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_puf_response_collector.sv
// Self-checking bench for puf_response_collector with a behavioural race-arbiter model and a reference response model.
module tb_puf_response_collector;
  localparam int RB = 8;
  localparam int CW = 8;
  localparam int SC = 4;
  localparam int TC = 255;
`ifdef PUF_MAJORITY_VOTE_EN
  localparam int RPB = 3;
`else
  localparam int RPB = 1;
`endif
  localparam int RUN_BOUND = RB * RPB * (SC + TC + 3);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] challenge_seed = '0;
  logic          busy, arb_reset, launch, resp_valid, timeout_err;
  logic [CW-1:0] chal_out;
  logic          arb_done = 1'b0;
  logic          arb_out = 1'b0;
  logic [RB-1:0] response;
  logic          resp_ready = 1'b0;

  int errors = 0;
  int checks = 0;

  puf_response_collector #(
    .RESP_BITS(RB), .CHAL_WIDTH(CW), .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .challenge_seed(challenge_seed),
    .busy(busy), .chal_out(chal_out), .arb_reset(arb_reset), .launch(launch),
    .arb_done(arb_done), .arb_out(arb_out), .response(response),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Arbiter model: counts races, logs the applied challenge, answers one cycle after launch.
  int            race_num = 0;
  int            suppress_abs = -1;
  int            mode = 0;
  int            pat_base = 0;
  logic [2:0]    pat = 3'b000;
  logic [CW-1:0] chal_log [0:1023];
  logic          launch_prev = 1'b0;
  logic          cur_supp = 1'b0;

  always @(posedge clk) begin
    #2;
    if (launch && !launch_prev) begin
      chal_log[race_num % 1024] = chal_out;
      if (mode == 0) arb_out = chal_out[0];
      else           arb_out = pat[(race_num - pat_base) % 3];
      cur_supp = (race_num == suppress_abs);
      race_num++;
    end
    arb_done    = launch && !cur_supp;
    launch_prev = launch;
  end

  function automatic logic [RB-1:0] ref_response(input logic [CW-1:0] seed, input int supp_rel,
                                                 input int m, input logic [2:0] p);
    logic [RB-1:0] r;
    logic [CW-1:0] c;
    int            votes;
    logic          s;
    r = '0;
    for (int i = 0; i < RB; i++) begin
      c = seed + CW'(i);
      votes = 0;
      for (int k = 0; k < RPB; k++) begin
        int rr;
        rr = i * RPB + k;
        if (rr == supp_rel) s = 1'b0;
        else if (m == 0)    s = c[0];
        else                s = p[rr % 3];
        votes += int'(s);
      end
      r = {r[RB-2:0], (votes * 2 > RPB)};
    end
    return r;
  endfunction

  task automatic run_collect(input logic [CW-1:0] seed, input int supp_rel, input string tag,
                             output logic [RB-1:0] got);
    int            base, cyc;
    logic          busy_ok, chal_ok, exp_to;
    logic [RB-1:0] exp_r;
    logic [CW-1:0] exp_c;
    base = race_num;
    pat_base = base;
    suppress_abs = (supp_rel < 0) ? -1 : base + supp_rel;
    @(negedge clk);
    start = 1'b1;
    challenge_seed = seed;
    @(negedge clk);
    start = 1'b0;
    challenge_seed = ~seed;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_start: got %b need 1", tag, busy); end
    cyc = 0;
    busy_ok = 1'b1;
    while (!resp_valid && cyc < RUN_BOUND + 20) begin
      @(negedge clk);
      cyc++;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    checks++;
    if (resp_valid !== 1'b1 || cyc > RUN_BOUND) begin
      errors++; $display("FAIL %s_latency: valid=%b after %0d cycles, bound %0d", tag, resp_valid, cyc, RUN_BOUND);
    end
    checks++;
    if (!busy_ok) begin errors++; $display("FAIL %s_busy_held: busy dropped during collection", tag); end
    exp_r = ref_response(seed, supp_rel, mode, pat);
    checks++;
    if (response !== exp_r) begin errors++; $display("FAIL %s_response: got %b need %b", tag, response, exp_r); end
    exp_to = (supp_rel >= 0) && (supp_rel < RB * RPB);
    checks++;
    if (timeout_err !== exp_to) begin errors++; $display("FAIL %s_timeout_err: got %b need %b", tag, timeout_err, exp_to); end
    checks++;
    if (race_num - base != RB * RPB) begin
      errors++; $display("FAIL %s_race_count: got %0d need %0d", tag, race_num - base, RB * RPB);
    end
    chal_ok = 1'b1;
    for (int r = 0; r < RB * RPB; r++) begin
      exp_c = seed + CW'(r / RPB);
      if (chal_log[(base + r) % 1024] !== exp_c && chal_ok) begin
        chal_ok = 1'b0;
        $display("FAIL %s_challenge: race %0d got %h need %h", tag, r, chal_log[(base + r) % 1024], exp_c);
      end
    end
    checks++;
    if (!chal_ok) errors++;
    got = response;
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s_handshake: valid=%b busy=%b need 0 0", tag, resp_valid, busy);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, arb_reset, launch, resp_valid, timeout_err} !== 5'b01000 || response !== '0 || chal_out !== '0) begin
      errors++;
      $display("FAIL reset_values: busy=%b arb_reset=%b launch=%b valid=%b to=%b resp=%h chal=%h need 0 1 0 0 0 00 00",
               busy, arb_reset, launch, resp_valid, timeout_err, response, chal_out);
    end
    reset = 1'b0;
    resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || arb_reset !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL idle_ready_early: busy=%b arb_reset=%b valid=%b need 0 1 0", busy, arb_reset, resp_valid);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_ideal();
    logic [RB-1:0] got;
    mode = 0;
    run_collect(8'h00, -1, "ideal_seed00", got);
    handshake("ideal_seed00");
  endtask

  task automatic test_wrap();
    logic [RB-1:0] got;
    mode = 0;
    run_collect(8'hFE, -1, "wrap_seedFE", got);
    handshake("wrap_seedFE");
  endtask

  task automatic test_timeout();
    logic [RB-1:0] got;
    mode = 0;
    run_collect(CW'($urandom), 3, "timeout_bit3", got);
    handshake("timeout_bit3");
  endtask

  task automatic test_hold();
    logic [RB-1:0] got;
    logic          ok;
    mode = 0;
    run_collect(8'h35, -1, "hold", got);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      start = (i % 5 == 2);
      challenge_seed = 8'hA0;
      @(negedge clk);
      if (resp_valid !== 1'b1 || response !== got || busy !== 1'b1) ok = 1'b0;
    end
    start = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL hold_stable: valid=%b resp=%h busy=%b need 1 %h 1", resp_valid, response, busy, got); end
    resp_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    start = 1'b0;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_release: valid=%b busy=%b need 0 0", resp_valid, busy);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || arb_reset !== 1'b1) begin
      errors++; $display("FAIL start_on_handshake_ignored: busy=%b arb_reset=%b need 0 1", busy, arb_reset);
    end
  endtask

  task automatic test_reset_mid();
    int            base, cyc;
    logic [RB-1:0] got;
    mode = 0;
    base = race_num;
    pat_base = base;
    suppress_abs = -1;
    @(negedge clk);
    start = 1'b1;
    challenge_seed = 8'h11;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(launch && race_num - base == 5 * RPB + 1) && cyc < RUN_BOUND) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!launch) begin errors++; $display("FAIL reset_mid_reach: launch=%b after %0d cycles, need 1", launch, cyc); end
    reset = 1'b1;
    #1;
    checks++;
    if (arb_reset !== 1'b1 || launch !== 1'b0 || busy !== 1'b0 || response !== '0 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_values: arb_reset=%b launch=%b busy=%b resp=%h valid=%b need 1 0 0 00 0",
               arb_reset, launch, busy, response, resp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_collect(8'h6C, -1, "after_reset", got);
    handshake("after_reset");
  endtask

  task automatic test_random();
    logic [RB-1:0] got;
    int            supp;
    for (int n = 0; n < 3; n++) begin
      mode = $urandom_range(0, 1);
      pat = 3'($urandom);
      supp = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, RB * RPB - 1)) : -1;
      run_collect(CW'($urandom), supp, "random", got);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      handshake("random");
    end
  endtask

`ifdef PUF_MAJORITY_VOTE_EN
  task automatic test_majority();
    logic [RB-1:0] got;
    mode = 1;
    pat = 3'b101;
    run_collect(8'h20, -1, "vote_101", got);
    checks++;
    if (got !== 8'hFF) begin errors++; $display("FAIL vote_101_word: got %h need ff", got); end
    handshake("vote_101");
    pat = 3'b100;
    run_collect(8'h20, -1, "vote_001", got);
    checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL vote_001_word: got %h need 00", got); end
    handshake("vote_001");
  endtask
`endif

  initial begin
    test_reset();
    test_ideal();
    test_wrap();
    test_timeout();
    test_hold();
    test_reset_mid();
    test_random();
`ifdef PUF_MAJORITY_VOTE_EN
    test_majority();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
